// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data SRAM arbiter.
// Port indices select bits of the req/gnt vectors.
package mem_arb_pkg;
    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;
    localparam int   DEF_ADDR_W = 13;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Combinational grant from req and the
// last-served register, so a lone requester is granted the same cycle.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0: instr served most recently, 1: data served most recently
    logic r_last;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req[PORT_INSTR] && req[PORT_DATA]) begin
                gnt[PORT_INSTR] = r_last;
                gnt[PORT_DATA]  = ~r_last;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset to "data was last" so boot fetch wins the first contention.
    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b1;
        else if (|gnt)
            r_last <= gnt[PORT_DATA];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between the core's fetch and load/store ports.
// One access per cycle; each response returns one cycle after its grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              instr_req,
    input  logic [31:0]       instr_addr,
    output logic              instr_gnt,
    output logic              instr_rvalid,
    output logic [31:0]       instr_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       r_instr_rvalid;
    logic       r_data_rvalid;
    logic       w_unused_addr_bits;

    assign w_req[PORT_INSTR] = instr_req;
    assign w_req[PORT_DATA]  = data_req;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (w_req),
        .gnt (w_gnt)
    );

    assign instr_gnt = w_gnt[PORT_INSTR];
    assign data_gnt  = w_gnt[PORT_DATA];

    assign mem_en    = |w_gnt;
    assign mem_addr  = w_gnt[PORT_DATA] ? data_addr[ADDR_W+1:2] : instr_addr[ADDR_W+1:2];
    assign mem_we    = w_gnt[PORT_DATA] ? (data_be & {4{data_we}}) : 4'b0000;
    assign mem_wdata = data_wdata;

    // Both ports see SRAM data; rvalid says whose it is.
    assign instr_rdata = mem_rdata;
    assign data_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
        end else begin
            r_instr_rvalid <= w_gnt[PORT_INSTR];
            r_data_rvalid  <= w_gnt[PORT_DATA];
        end
    end

    assign instr_rvalid = r_instr_rvalid;
    assign data_rvalid  = r_data_rvalid;

    // Decode and alignment belong to the bus and core; these bits are dropped.
    assign w_unused_addr_bits = ^{instr_addr[31:ADDR_W+2], instr_addr[1:0],
                                  data_addr[31:ADDR_W+2], data_addr[1:0]};

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing one single-port synchronous SRAM between the cv32e40p instruction fetch interface and data load/store interface. Sits beside `bus`, behind its RAM address decode, and speaks the core's OBI-style req/gnt/rvalid protocol on both sides. Issues at most one RAM access per cycle. Returns each response exactly one cycle after its grant, routed to the port that owned the access.

## Interface
- `ADDR_W`, default 13: word-address width of the SRAM (2^13 words = 32 KiB).
- `clk` in 1: single clock, shared with core and `bus`.
- `rst` in 1: synchronous, active-high reset.
- `instr_req` in 1: fetch request.
- `instr_addr` in 32: byte address; bits [ADDR_W+1:2] used.
- `instr_gnt` out 1: fetch accepted this cycle.
- `instr_rvalid` out 1: fetch data valid.
- `instr_rdata` out 32: fetch data.
- `data_req` in 1: load/store request.
- `data_we` in 1: 1 = store.
- `data_be` in 4: byte enables.
- `data_addr` in 32: byte address; bits [ADDR_W+1:2] used.
- `data_wdata` in 32: store data.
- `data_gnt` out 1: data access accepted.
- `data_rvalid` out 1: data response, for loads and stores.
- `data_rdata` out 32: load data.
- `mem_en` out 1: SRAM access strobe.
- `mem_we` out 4: per-byte write enable.
- `mem_addr` out ADDR_W: SRAM word address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, valid the cycle after `mem_en`.

## Operation
- Grant logic is combinational from the `*_req` inputs and the `last` register.
- Only one requester active: that requester is granted the same cycle.
- Both requesters active: grant the port not granted most recently. `last` = 0 means instr was last, 1 means data was last.
- `last` updates only on a cycle that carries a grant.
- Granted cycle outputs:
  - `mem_en` = 1.
  - `mem_addr` = the owner's addr[ADDR_W+1:2].
  - `mem_we` = `data_be` & {4{`data_we`}} when the owner is data, otherwise 0.
  - `mem_wdata` = `data_wdata`.
- No grant: `mem_en` = 0 and `mem_we` = 0.
- Registered response state, updated every cycle:
  - `instr_rvalid` <= `instr_gnt`.
  - `data_rvalid` <= `data_gnt`.
- `instr_rdata` and `data_rdata` are both driven directly from `mem_rdata`. The response is only meaningful while the matching rvalid is high.
- A store gets `data_rvalid` like a load. Its rdata is don't-care.
- Address bits above ADDR_W+1 and bits [1:0] are ignored. Decode and alignment are the job of `bus` and the core.
- At most one outstanding transaction per port. The core cannot issue back-to-back requests faster than one per cycle, so no FIFO is needed.
- Reset values: `last` = 1, so the first contention goes to instr and boot fetch proceeds. `instr_rvalid` = 0, `data_rvalid` = 0.
- While `rst` is high: all grants and `mem_en` are forced to 0.
- Reset asserted mid-transaction: any pending rvalid is dropped the next edge.

## Timing
- Grant latency: 0 cycles (same cycle as req).
- Response latency: exactly 1 cycle after the grant edge.
- Throughput: 1 access per cycle total.
- Under continuous contention the ports alternate, giving each port 50 %.
- Worst-case wait for a requesting port: 1 cycle.
- Simultaneous grant on cycle N and response on cycle N: allowed and independent. Cycle N's response belongs to cycle N-1's owner.
- `instr_rvalid` and `data_rvalid` are never high in the same cycle.
- Combinational path req → gnt → mem_addr/mem_we must meet one `clk` period. No pipelining of the SRAM port is added.

## Structure
- Package `mem_arb_pkg` holds:
  - localparams `PORT_INSTR` = 1'b0 and `PORT_DATA` = 1'b1.
  - the default `ADDR_W`.
- One sub-module, `rr_arb2`:
  - two-input round-robin arbiter with the `last` register.
  - inputs: `clk`, `rst`, req[1:0]. Outputs: gnt[1:0] (one-hot or zero).
- The top level does the muxing, write-enable gating and the rvalid registers.

## Test plan
- Reset, then `instr_req` alone to addr 0x100 with the word preloaded to 0xDEADBEEF: `instr_gnt` = 1 the same cycle and `mem_addr` = 0x40. Next cycle `instr_rvalid` = 1 and `instr_rdata` = 0xDEADBEEF. `data_rvalid` stays 0.
- Store to 0x8 with be = 4'b0011 and wdata = 0x12345678 over a preloaded 0xAAAAAAAA, then load 0x8: `mem_we` = 4'b0011 on the store, `data_rvalid` 1 cycle after each grant, and the load returns 0xAAAA5678.
- Both ports request continuously for 6 cycles right after reset: grants run instr, data, instr, data, instr, data. Each rvalid follows its grant by 1 cycle. No cycle has two grants.
- Reset, then data requests alone for 3 cycles before instr joins: data is granted cycles 0–2, then instr wins the first contention cycle because `last` = data.
- Assert `rst` the cycle after a data grant: `data_rvalid` = 0 the next cycle, and every grant and `mem_en` is 0 while reset is held.
